uart_rx_fifo: RTL and testbench

UART receive front-end that feeds the SoC's memory-mapped UART RX register. It synchronises the serial line, deframes 8N1 characters by mid-bit sampling, and buffers received bytes in a small FIFO. It presents the FIFO head as a 32-bit word. The bus side pops one entry per data_rd pulse and reads all-ones when the FIFO is empty; the LSR "data ready" bit is derived from that all-ones value.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo_sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;
  localparam int          UART_DIV_MIN    = 2;

  // Divisors below the minimum would leave no room for mid-bit sampling.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'(UART_DIV_MIN)) ? 16'(UART_DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Circular byte buffer; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, rp_q, level_q;
  logic             do_pop, do_push;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // A pop in the same cycle frees the slot a push on a full buffer needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rp_q[AW-1:0]];
  assign level   = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: line synchroniser, mid-bit sampling deframer and RX byte FIFO
// exposed as a 32-bit register word (all-ones when empty).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  input  logic [15:0]                   div,
  input  logic                          data_rd,
  output logic [31:0]                   data,
  output logic                          error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q, rx_s, fall;

  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        brk_q, brk_d;
  logic        error_q, overrun_q;
  logic        good, err_d, overrun_d;

  logic        fifo_full, fifo_empty;
  logic [7:0]  head;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 16'(UART_DIV_MIN);
      bit_q     <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      error_q   <= err_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    good    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          div_d   = eff_div(div);
          cnt_d   = eff_div(div) >> 1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rx_s) begin
          cnt_d   = div_q - 16'd1;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = div_q - 16'd1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line idles so a break
        // does not turn into a run of 0x00 characters.
        if (brk_q) begin
          if (rx_s) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s) begin
          good    = 1'b1;
          state_d = IDLE;
        end else begin
          err_d = 1'b1;
          brk_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_d = good & fifo_full & ~data_rd;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (good),
    .wdata (shift_q),
    .pop   (data_rd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (rx_level)
  );

  assign data    = fifo_empty ? UART_EMPTY_WORD : {24'h0, head};
  assign error   = error_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo against a queue-based receive model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst, rx_in, data_rd;
  logic [15:0] div;
  logic [31:0] data;
  logic        error, overrun;
  logic [4:0]  rx_level;

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .div(div), .data_rd(data_rd),
    .data(data), .error(error), .overrun(overrun), .rx_level(rx_level)
  );

  int n_tests = 0, n_fail = 0;
  int err_seen = 0, ovr_seen = 0;

  typedef struct { int rem; bit good; logic [7:0] b; } ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         exp_err, exp_ovr;
  bit         running = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges from the start edge on rx_in to the stop-bit decision:
  // synchroniser, edge detect, half a bit, then eight data bits and the stop bit.
  function automatic int lat(input int d);
    int e;
    e = (d < 2) ? 2 : d;
    return SYNC + 2 + e / 2 + 9 * e;
  endfunction

  // Reference model: a byte queue plus scheduled frame-completion events.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      evq.delete();
      exp_err = 1'b0;
      exp_ovr = 1'b0;
    end else begin
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      if (data_rd && mq.size() != 0) void'(mq.pop_front());
      for (int i = 0; i < evq.size(); i++) evq[i].rem--;
      while (evq.size() != 0 && evq[0].rem <= 0) begin
        ev_t e;
        e = evq.pop_front();
        if (!e.good)                exp_err = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(e.b);
        else                        exp_ovr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_data;
    exp_data = (mq.size() == 0) ? 32'hFFFF_FFFF : {24'h0, mq[0]};
    if (running) begin
      check("data", data, exp_data);
      check("rx_level", 32'(rx_level), 32'(mq.size()));
      check("error", 32'(error), 32'(exp_err));
      check("overrun", 32'(overrun), 32'(exp_ovr));
    end
    if (error)   err_seen++;
    if (overrun) ovr_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int d, input bit stop_ok, input int stop_bits);
    div = 16'(d);
    evq.push_back('{rem: lat(d), good: stop_ok, b: b});
    rx_in = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(d);
    end
    rx_in = stop_ok;
    tick(d * stop_bits);
    rx_in = 1'b1;
    tick(d);
  endtask

  task automatic pop1();
    data_rd = 1'b1;
    tick(1);
    data_rd = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, o0;
    rst = 1'b1; rx_in = 1'b1; data_rd = 1'b0; div = 16'd16;
    tick(3);
    check("rst_data", data, 32'hFFFF_FFFF);
    check("rst_level", 32'(rx_level), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single 0x55 at div=16, then pop it.
    send(8'h55, 16, 1'b1, 1);
    check("t1_data", data, 32'h0000_0055);
    check("t1_level", 32'(rx_level), 32'd1);
    pop1();
    check("t1_pop_data", data, 32'hFFFF_FFFF);
    check("t1_pop_level", 32'(rx_level), 32'd0);

    // Short glitch on the line must not start a character.
    e0 = err_seen;
    div = 16'd16;
    rx_in = 1'b0; tick(4); rx_in = 1'b1; tick(200);
    check("t2_data", data, 32'hFFFF_FFFF);
    check("t2_no_err", 32'(err_seen), 32'(e0));

    // Framing error with a two-bit-time low stop, then a good character.
    e0 = err_seen;
    send(8'hA3, 8, 1'b0, 2);
    check("t3_err_once", 32'(err_seen), 32'(e0 + 1));
    check("t3_empty", 32'(rx_level), 32'd0);
    send(8'h3C, 8, 1'b1, 1);
    check("t3_data", data, 32'h0000_003C);
    pop1();

    // Seventeen bytes into a 16-deep FIFO without popping.
    o0 = ovr_seen;
    for (int i = 0; i < 17; i++) send(8'(i), 4, 1'b1, 1);
    check("t4_ovr_once", 32'(ovr_seen), 32'(o0 + 1));
    check("t4_level", 32'(rx_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t4_order", data, 32'(i));
      pop1();
    end
    check("t4_drained", data, 32'hFFFF_FFFF);

    // Pop on the exact edge the 17th byte lands in a full FIFO.
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 4, 1'b1, 1);
    o0 = ovr_seen;
    fork
      send(8'h99, 4, 1'b1, 1);
      begin
        tick(lat(4) - 1);
        data_rd = 1'b1;
        tick(1);
        data_rd = 1'b0;
      end
    join
    check("t5_no_ovr", 32'(ovr_seen), 32'(o0));
    check("t5_level", 32'(rx_level), 32'd16);
    check("t5_head", data, 32'h0000_0041);
    for (int i = 0; i < 15; i++) pop1();
    check("t5_last", data, 32'h0000_0099);
    pop1();

    // Reset mid-frame with three bytes buffered.
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 8, 1'b1, 1);
    div = 16'd8;
    rx_in = 1'b0; tick(8);
    rx_in = 1'b1; tick(8);
    rx_in = 1'b0; tick(12);
    rst = 1'b1;
    data_rd = 1'b1;
    #1;
    check("t6_rst_data", data, 32'hFFFF_FFFF);
    check("t6_rst_level", 32'(rx_level), 32'd0);
    rx_in = 1'b1;
    tick(3);
    data_rd = 1'b0;
    rst = 1'b0;
    tick(16);
    send(8'h7E, 8, 1'b1, 1);
    check("t6_data", data, 32'h0000_007E);
    pop1();
    pop1();
    check("t6_empty_pop", data, 32'hFFFF_FFFF);
    check("t6_empty_level", 32'(rx_level), 32'd0);

    // Random characters, divisors and concurrent random pops.
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 30; i++)
            send(8'($urandom_range(0, 255)), int'($urandom_range(4, 9)), 1'b1, 1);
          done = 1'b1;
        end
        begin
          while (!done) begin
            data_rd = ($urandom_range(0, 11) == 0);
            tick(1);
          end
          data_rd = 1'b0;
        end
      join
    end
    for (int i = 0; i < DEPTH + 1; i++) pop1();
    check("rand_drained", data, 32'hFFFF_FFFF);

    running = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
